uart_tx_arbiter: RTL
====================

Name: uart_tx_arbiter

Overview:
- Round-robin arbiter sharing one uart_tx serializer between NUM_REQ byte producers (command handler, status reporter, loopback echo from uart_rx, etc.).
- Captures the winning requester's byte, issues a single-cycle start to the transmitter, and waits for its done pulse before granting again.
- A watchdog recovers the arbiter if the transmitter never reports completion.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_BITS, 8, byte width; matches uart_tx/uart_rx.
- TIMEOUT_CYCLES, 4096, maximum cycles in WAIT_DONE before abort (>=2).

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- req  input  NUM_REQ  per-requester request; held high until ack.
- req_data  input  NUM_REQ*DATA_BITS  byte of requester i at bits [i*DATA_BITS +: DATA_BITS].
- ack  output  NUM_REQ  one-hot, one-cycle pulse: byte accepted.
- tx_start  output  1  one-cycle start pulse to uart_tx.
- tx_data  output  DATA_BITS  byte to transmit; stable from ISSUE until return to IDLE.
- tx_busy  input  1  uart_tx currently serializing.
- tx_done  input  1  one-cycle pulse when uart_tx finishes the stop bit.
- active_id  output  clog2(NUM_REQ)  index of the current or last granted requester.
- arb_busy  output  1  high in any state other than IDLE.
- timeout_err  output  1  one-cycle pulse when the watchdog aborts a transfer.

Behaviour:
- All outputs are registered.
- Reset (reset=0, asynchronous): state=IDLE, rr_ptr=0, and ack, tx_start, tx_data, active_id, arb_busy, timeout_err, wdog are all 0.
- Reset mid-transfer aborts immediately. No ack or tx_start is reissued. The requester must re-request.
- FSM states: IDLE, ISSUE, WAIT_DONE.
- IDLE:
  - If any req bit is high and tx_busy=0, pick the winner: the first set bit of req searching rr_ptr, rr_ptr+1, ... with wrap modulo NUM_REQ.
  - On that edge: latch tx_data=req_data[winner], set active_id=winner, go to ISSUE.
  - If tx_busy=1, stay in IDLE; no grant.
- ISSUE (exactly 1 cycle): tx_start=1, ack[active_id]=1, arb_busy=1; clear wdog; go to WAIT_DONE.
- WAIT_DONE:
  - tx_start=0; wdog increments each cycle.
  - tx_done=1: go to IDLE, rr_ptr=(active_id+1) mod NUM_REQ.
  - Otherwise, if wdog==TIMEOUT_CYCLES-1: pulse timeout_err for 1 cycle, go to IDLE, advance rr_ptr the same way.
  - tx_done on the same cycle as the timeout threshold counts as success; no timeout_err.
- Latency:
  - req sampled high at edge k (arbiter idle, tx_busy low) gives tx_start and ack high during cycle k+1.
  - Minimum back-to-back spacing is the tx_done edge, then 1 IDLE cycle, then ISSUE.
- tx_done is ignored outside WAIT_DONE, including during ISSUE.
- Data is captured at grant. After ack, the requester may change req_data or drop req.
- Dropping req before ack:
  - Legal while the arbiter is in IDLE; the requester is not granted.
  - After the grant edge the byte is already committed and is still sent.
- Requester i re-asserting req right after ack gets no second grant until every other pending requester has been served once (fairness).
- Single requester continuously asserting: served every transfer. rr_ptr still advances, and the wrap search returns to it.
- active_id holds its value in IDLE.
- wdog width is clog2(TIMEOUT_CYCLES+1). It never wraps; it is cleared in ISSUE.

Test Plan:
- Reset then single request: release reset, req=4'b0001, req_data[7:0]=8'hA5. Required: tx_start and ack=4'b0001 one cycle after the sampled req, tx_data=8'hA5. Model tx_done 20 cycles later; arb_busy falls on that edge.
- Round-robin fairness: req=4'b1111 with bytes 11,22,33,44, held continuously, tx_done 10 cycles after each start. Required: grant order 0,1,2,3,0 and tx_data sequence 11,22,33,44,11.
- Wrap and skip: rr_ptr=3 (after serving id 2), req=4'b0101. Required: id 0 granted next, then id 2. Ids 1 and 3 are never acked.
- Busy gating and stale done: tx_busy=1 with req=4'b0010 produces no grant; grant follows one cycle after tx_busy falls. A tx_done pulse injected while in IDLE or ISSUE changes no state.
- Watchdog: TIMEOUT_CYCLES=16, tx_done never sent. Required: timeout_err pulses exactly 16 cycles after the ISSUE cycle, state returns to IDLE, next pending requester is granted. Repeat with tx_done on the threshold cycle: no timeout_err.
- Async reset mid-transfer: assert reset (low) in WAIT_DONE between clock edges. Required: outputs go to 0 immediately without waiting for a clock edge. After release, the still-asserted req=4'b0100 is granted to id 2 with a fresh ack, and rr_ptr restarts from 0.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx between byte producers.
// Grants, issues a start pulse, then waits for done or a watchdog abort.
module uart_tx_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int DATA_BITS      = 8,
  parameter int TIMEOUT_CYCLES = 4096,
  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int WDW = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ*DATA_BITS-1:0]   req_data,
  output logic [NUM_REQ-1:0]             ack,
  output logic                           tx_start,
  output logic [DATA_BITS-1:0]           tx_data,
  input  logic                           tx_busy,
  input  logic                           tx_done,
  output logic [IDW-1:0]                 active_id,
  output logic                           arb_busy,
  output logic                           timeout_err
);

  localparam int CW = IDW + 1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_DONE
  } state_e;

  state_e               state_q, state_d;
  logic [IDW-1:0]       rr_ptr_q, rr_ptr_d;
  logic [WDW-1:0]       wdog_q, wdog_d;
  logic [NUM_REQ-1:0]   ack_q, ack_d;
  logic                 tx_start_q, tx_start_d;
  logic [DATA_BITS-1:0] tx_data_q, tx_data_d;
  logic [IDW-1:0]       active_id_q, active_id_d;
  logic                 arb_busy_q, arb_busy_d;
  logic                 timeout_err_q, timeout_err_d;

  logic [CW-1:0]        cand;
  logic [IDW-1:0]       win;
  logic                 found;
  logic [DATA_BITS-1:0] win_byte;
  logic [IDW-1:0]       next_ptr;

  // First set req bit searching upward from rr_ptr with wrap.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = {1'b0, rr_ptr_q} + CW'(i);
      if (cand >= CW'(NUM_REQ)) cand = cand - CW'(NUM_REQ);
      if (!found && req[cand[IDW-1:0]]) begin
        found = 1'b1;
        win   = cand[IDW-1:0];
      end
    end
  end

  // Byte mux for the winning requester.
  always_comb begin
    win_byte = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win == IDW'(i)) win_byte = req_data[i*DATA_BITS +: DATA_BITS];
    end
  end

  assign next_ptr = (active_id_q == IDW'(NUM_REQ - 1)) ? '0
                  : active_id_q + IDW'(1);

  // Next-state and registered-output logic.
  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    wdog_d        = wdog_q;
    ack_d         = '0;
    tx_start_d    = 1'b0;
    tx_data_d     = tx_data_q;
    active_id_d   = active_id_q;
    timeout_err_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (found && !tx_busy) begin
          state_d     = ISSUE;
          tx_data_d   = win_byte;
          active_id_d = win;
          tx_start_d  = 1'b1;
          ack_d[win]  = 1'b1;
        end
      end
      ISSUE: begin
        wdog_d  = '0;
        state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        wdog_d = wdog_q + WDW'(1);
        if (tx_done) begin
          state_d  = IDLE;
          rr_ptr_d = next_ptr;
        end else if (wdog_q == WDW'(TIMEOUT_CYCLES - 1)) begin
          state_d       = IDLE;
          rr_ptr_d      = next_ptr;
          timeout_err_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    arb_busy_d = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      rr_ptr_q      <= '0;
      wdog_q        <= '0;
      ack_q         <= '0;
      tx_start_q    <= 1'b0;
      tx_data_q     <= '0;
      active_id_q   <= '0;
      arb_busy_q    <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      wdog_q        <= wdog_d;
      ack_q         <= ack_d;
      tx_start_q    <= tx_start_d;
      tx_data_q     <= tx_data_d;
      active_id_q   <= active_id_d;
      arb_busy_q    <= arb_busy_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign ack         = ack_q;
  assign tx_start    = tx_start_q;
  assign tx_data     = tx_data_q;
  assign active_id   = active_id_q;
  assign arb_busy    = arb_busy_q;
  assign timeout_err = timeout_err_q;

endmodule
